// File: rtl/card_frame_decoder.sv
// Byte-stream tap-frame decoder feeding the fare-gate FSM.
// Takes a five-byte frame (sync, flags, balance lo/hi, xor checksum) and publishes registered card status.
module card_frame_decoder #(
  parameter logic [15:0] FARE     = 16'd325,
  parameter int          NFC_HOLD = 2,
  parameter int          TIMEOUT  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_valid,
  input  logic [7:0] rx_byte,
  output logic       rx_ready,
  output logic       nfc,
  output logic       card_active,
  output logic       monthly,
  output logic       fund_enough,
  output logic       frame_err
);

  localparam int CNT_MAX = (TIMEOUT > NFC_HOLD) ? TIMEOUT : NFC_HOLD;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [7:0] SYNC = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE, S_FLAGS, S_BAL_LO, S_BAL_HI, S_CHK, S_EMIT
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    flags_q, flags_d;
  logic [7:0]    bal_lo_q, bal_lo_d;
  logic [7:0]    bal_hi_q, bal_hi_d;
  logic          nfc_q, nfc_d;
  logic          act_q, act_d;
  logic          mon_q, mon_d;
  logic          fund_q, fund_d;
  logic          err_q, err_d;

  logic          accept;
  logic          chk_ok;
  logic          timed_out;
  logic [15:0]   balance;

  assign accept    = rx_valid & rx_ready;
  assign balance   = {bal_hi_q, bal_lo_q};
  assign chk_ok    = (rx_byte == (flags_q ^ bal_lo_q ^ bal_hi_q));
  // An accepted byte on the final idle cycle takes priority over the timeout.
  assign timed_out = !accept && (cnt_q == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      flags_q  <= '0;
      bal_lo_q <= '0;
      bal_hi_q <= '0;
      nfc_q    <= 1'b0;
      act_q    <= 1'b0;
      mon_q    <= 1'b0;
      fund_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      flags_q  <= flags_d;
      bal_lo_q <= bal_lo_d;
      bal_hi_q <= bal_hi_d;
      nfc_q    <= nfc_d;
      act_q    <= act_d;
      mon_q    <= mon_d;
      fund_q   <= fund_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    flags_d  = flags_q;
    bal_lo_d = bal_lo_q;
    bal_hi_d = bal_hi_q;
    act_d    = act_q;
    mon_d    = mon_q;
    fund_d   = fund_q;
    err_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (accept && (rx_byte == SYNC)) state_d = S_FLAGS;
      end
      S_FLAGS, S_BAL_LO, S_BAL_HI, S_CHK: begin
        if (accept) begin
          cnt_d = '0;
          case (state_q)
            S_FLAGS: begin
              flags_d = rx_byte;
              state_d = S_BAL_LO;
            end
            S_BAL_LO: begin
              bal_lo_d = rx_byte;
              state_d  = S_BAL_HI;
            end
            S_BAL_HI: begin
              bal_hi_d = rx_byte;
              state_d  = S_CHK;
            end
            default: begin
              if (chk_ok) begin
                state_d = S_EMIT;
                act_d   = flags_q[0];
                mon_d   = flags_q[1];
                fund_d  = (balance >= FARE);
              end else begin
                state_d = S_IDLE;
                err_d   = 1'b1;
              end
            end
          endcase
        end else if (timed_out) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_EMIT: begin
        // Counter reused as the strobe-length timer; it was cleared on the CHK byte.
        if (cnt_q == CW'(NFC_HOLD - 1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    nfc_d = (state_d == S_EMIT);
  end

  always_comb begin
    rx_ready    = (state_q != S_EMIT);
    nfc         = nfc_q;
    card_active = act_q;
    monthly     = mon_q;
    fund_enough = fund_q;
    frame_err   = err_q;
  end

endmodule

// File: tb/tb_card_frame_decoder.sv
// Scoreboard bench for card_frame_decoder: a frame table plus hand-built timeout,
// EMIT back-pressure and mid-frame reset sequences.
module tb_card_frame_decoder;

  localparam int NFC_HOLD = 2;
  localparam int TIMEOUT  = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       rx_ready, nfc, card_active, monthly, fund_enough, frame_err;

  card_frame_decoder #(
    .FARE(16'd325), .NFC_HOLD(NFC_HOLD), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_byte(rx_byte),
    .rx_ready(rx_ready), .nfc(nfc), .card_active(card_active),
    .monthly(monthly), .fund_enough(fund_enough), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] b [5];
    bit good;
    bit act;
    bit mon;
    bit fund;
  } vec_t;

  typedef struct {
    bit good;
    bit act;
    bit mon;
    bit fund;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   m_act = 1'b0, m_mon = 1'b0, m_fund = 1'b0;
  int   run = 0;
  bit   nfc_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (cycle %0d)", name, got, req, cyc);
    end
  endtask

  // Events are a rising nfc or a frame_err pulse; each must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (frame_err || (nfc && !nfc_prev)) begin
      if (sb.size() == 0) begin
        chk("unexpected_event", {30'd0, frame_err, nfc}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("event_nfc", nfc, e.good);
        chk("event_err", frame_err, !e.good);
        chk("event_cycle", cyc, e.cyc);
        chk("card_active", card_active, e.act);
        chk("monthly", monthly, e.mon);
        chk("fund_enough", fund_enough, e.fund);
      end
    end
    if (nfc) run++;
    else begin
      if (nfc_prev) chk("nfc_width", run, NFC_HOLD);
      run = 0;
    end
    nfc_prev = nfc;
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int w;
    w = 0;
    rx_valid = 1'b1;
    rx_byte  = b;
    while (!rx_ready && w < 32) begin
      @(posedge clk);
      #1;
      w++;
    end
    if (!rx_ready) chk("rx_ready_wait", rx_ready, 1);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic expect_evt(input bit good, input bit a, input bit m, input bit f);
    exp_t e;
    e.good = good; e.act = a; e.mon = m; e.fund = f; e.cyc = cyc;
    if (good) begin
      m_act = a; m_mon = m; m_fund = f;
    end
    sb.push_back(e);
  endtask

  task automatic send_frame(input vec_t v);
    for (int i = 0; i < 5; i++) send_byte(v.b[i]);
    expect_evt(v.good, v.act, v.mon, v.fund);
  endtask

  function automatic vec_t mk(input logic [7:0] b0, b1, b2, b3, b4,
                              input bit good, input bit a, input bit m, input bit f);
    vec_t v;
    v.b[0] = b0; v.b[1] = b1; v.b[2] = b2; v.b[3] = b3; v.b[4] = b4;
    v.good = good; v.act = a; v.mon = m; v.fund = f;
    return v;
  endfunction

  initial begin
    vec_t tv [8];
    tv[0] = mk(8'hA5, 8'h01, 8'h90, 8'h01, 8'h90, 1, 1, 0, 1); // 400
    tv[1] = mk(8'hA5, 8'h01, 8'h44, 8'h01, 8'h44, 1, 1, 0, 0); // 324
    tv[2] = mk(8'hA5, 8'h01, 8'h45, 8'h01, 8'h45, 1, 1, 0, 1); // 325
    tv[3] = mk(8'hA5, 8'h03, 8'h00, 8'h00, 8'h03, 1, 1, 1, 0); // monthly, zero
    tv[4] = mk(8'hA5, 8'h00, 8'h90, 8'h01, 8'h91, 1, 0, 0, 1); // inactive
    tv[5] = mk(8'hA5, 8'h01, 8'h90, 8'h01, 8'h91, 0, 0, 0, 1); // bad chk, holds tv[4]
    tv[6] = mk(8'hA5, 8'h02, 8'hFF, 8'hFF, 8'h02, 1, 0, 1, 1); // 65535 unsigned
    tv[7] = mk(8'hA5, 8'h01, 8'hA5, 8'h00, 8'hA4, 1, 1, 0, 0); // sync value as data, 165

    idle(2);
    chk("rst_nfc", nfc, 0);
    chk("rst_rx_ready", rx_ready, 1);
    rst = 1'b1;
    idle(1);
    chk("reset_nfc", nfc, 0);
    chk("reset_card_active", card_active, 0);
    chk("reset_monthly", monthly, 0);
    chk("reset_fund_enough", fund_enough, 0);
    chk("reset_frame_err", frame_err, 0);
    chk("reset_rx_ready", rx_ready, 1);

    send_byte(8'h00);
    send_byte(8'h5A);
    for (int i = 0; i < 8; i++) begin
      send_frame(tv[i]);
      if (i == 1) send_byte(8'h33);
    end
    idle(4);

    // Byte offered during EMIT must not be consumed: the trailing bytes then fall in IDLE.
    send_frame(tv[0]);
    rx_valid = 1'b1;
    rx_byte  = 8'hA5;
    chk("rx_ready_emit0", rx_ready, 0);
    idle(1);
    rx_valid = 1'b0;
    chk("rx_ready_emit1", rx_ready, 0);
    send_byte(8'h01); send_byte(8'h90); send_byte(8'h01); send_byte(8'h90);
    idle(3);

    // A byte on the last idle cycle before the timeout is accepted.
    send_byte(8'hA5);
    idle(TIMEOUT - 1);
    send_byte(8'h01); send_byte(8'h44); send_byte(8'h01); send_byte(8'h44);
    expect_evt(1, 1, 0, 0);
    idle(4);

    // Full timeout: status holds, then a good frame decodes normally.
    send_byte(8'hA5);
    send_byte(8'h01);
    idle(TIMEOUT - 1);
    chk("no_early_timeout", frame_err, 0);
    idle(1);
    expect_evt(0, m_act, m_mon, m_fund);
    idle(2);
    send_frame(tv[2]);
    idle(4);

    // Mid-frame reset; leftovers are discarded.
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h90);
    rst = 1'b0;
    idle(1);
    rst = 1'b1;
    chk("midrst_nfc", nfc, 0);
    chk("midrst_card_active", card_active, 0);
    chk("midrst_monthly", monthly, 0);
    chk("midrst_fund_enough", fund_enough, 0);
    chk("midrst_frame_err", frame_err, 0);
    chk("midrst_rx_ready", rx_ready, 1);
    m_act = 1'b0; m_mon = 1'b0; m_fund = 1'b0;
    send_byte(8'h01); send_byte(8'h90);
    idle(3);
    send_frame(tv[3]);
    idle(6);

    chk("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
